// File: rtl/io_port_unit.sv
// Memory-mapped I/O port: registered output port, synchronized input port with
// change detection, sticky status flags and a transmit FIFO toward a stream consumer.
module io_port_unit #(
    parameter logic [31:0] BASE_ADDR  = 32'h10011000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic [31:0] ReadData,
    output logic        Hit,
    input  logic [7:0]  PortIn,
    output logic [31:0] PortOut,
    output logic [31:0] TxData,
    output logic        TxValid,
    input  logic        TxReady
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [4:0] DEPTH_C = 5'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        OFF_PORT_OUT = 2'd0,
        OFF_PORT_IN  = 2'd1,
        OFF_STATUS   = 2'd2,
        OFF_TX_DATA  = 2'd3
    } offset_e;

    logic          hit_s;
    offset_e       offset_s;
    logic          wr_s;
    logic          wr_port_out_s;
    logic          wr_status_s;
    logic          wr_tx_s;
    logic          unused_addr_s;

    logic [31:0]   port_out_r;
    logic [7:0]    s1_r;
    logic [7:0]    s2_r;
    logic [7:0]    s3_r;
    logic          chg_r;
    logic          ovf_r;

    logic [31:0]   mem_r [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [4:0]    count_r;
    logic          empty_s;
    logic          full_s;
    logic          pop_s;
    logic          push_s;
    logic          drop_s;
    logic          chg_set_s;
    logic [31:0]   status_s;

    // Address decode; the low byte-lane bits do not select a register.
    assign hit_s         = (Address[31:4] == BASE_ADDR[31:4]);
    assign offset_s      = offset_e'(Address[3:2]);
    assign wr_s          = MemWrite & hit_s;
    assign unused_addr_s = &{1'b0, Address[1:0]};

    // Per-register write strobes
    always_comb begin
        wr_port_out_s = 1'b0;
        wr_status_s   = 1'b0;
        wr_tx_s       = 1'b0;
        if (wr_s) begin
            case (offset_s)
                OFF_PORT_OUT: wr_port_out_s = 1'b1;
                OFF_STATUS:   wr_status_s   = 1'b1;
                OFF_TX_DATA:  wr_tx_s       = 1'b1;
                default:      wr_port_out_s = 1'b0;
            endcase
        end else begin
            wr_port_out_s = 1'b0;
        end
    end

    assign empty_s   = (count_r == 5'd0);
    assign full_s    = (count_r == DEPTH_C);
    assign pop_s     = !empty_s & TxReady;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_s    = wr_tx_s & (!full_s | pop_s);
    assign drop_s    = wr_tx_s & full_s & !pop_s;
    assign chg_set_s = (s2_r != s3_r);

    assign status_s  = {21'd0, count_r, 2'd0, ovf_r, full_s, empty_s, chg_r};

    // Output port register
    always_ff @(posedge clk) begin
        if (reset) begin
            port_out_r <= 32'd0;
        end else if (wr_port_out_s) begin
            port_out_r <= WriteData;
        end
    end

    // Input synchronizer plus one history stage for change detection
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_r <= 8'd0;
            s2_r <= 8'd0;
            s3_r <= 8'd0;
        end else begin
            s1_r <= PortIn;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    // Sticky change flag; a new change beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            chg_r <= 1'b0;
        end else if (chg_set_s) begin
            chg_r <= 1'b1;
        end else if (wr_status_s && WriteData[0]) begin
            chg_r <= 1'b0;
        end
    end

    // Sticky overflow flag; a dropped push beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_r <= 1'b0;
        end else if (drop_s) begin
            ovf_r <= 1'b1;
        end else if (wr_status_s && WriteData[3]) begin
            ovf_r <= 1'b0;
        end
    end

    // FIFO storage; contents need no reset because the pointers and count do
    always_ff @(posedge clk) begin
        if (!reset && push_s) begin
            mem_r[wr_ptr_r] <= WriteData;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= 5'd0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 5'd1;
                2'b01:   count_r <= count_r - 5'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Load data path; purely combinational so it shows pre-write values
    always_comb begin
        ReadData = 32'd0;
        if (MemRead && hit_s) begin
            case (offset_s)
                OFF_PORT_OUT: ReadData = port_out_r;
                OFF_PORT_IN:  ReadData = {24'd0, s2_r};
                OFF_STATUS:   ReadData = status_s;
                OFF_TX_DATA:  ReadData = 32'd0;
                default:      ReadData = 32'd0;
            endcase
        end else begin
            ReadData = 32'd0;
        end
    end

    assign Hit     = hit_s;
    assign PortOut = port_out_r;
    assign TxValid = !empty_s;
    assign TxData  = mem_r[rd_ptr_r];

endmodule

// File: tb/tb_io_port_unit.sv
// Directed bench for io_port_unit: register access, input synchronizer,
// status flags and transmit FIFO behaviour including reset mid-transfer.
module tb_io_port_unit;

    localparam logic [31:0] A_OUT = 32'h10011000;
    localparam logic [31:0] A_IN  = 32'h10011004;
    localparam logic [31:0] A_ST  = 32'h10011008;
    localparam logic [31:0] A_TX  = 32'h1001100C;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] ReadData;
    logic        Hit;
    logic [7:0]  PortIn;
    logic [31:0] PortOut;
    logic [31:0] TxData;
    logic        TxValid;
    logic        TxReady;

    int errors = 0;
    int checks = 0;

    io_port_unit dut (
        .clk(clk), .reset(reset), .Address(Address), .WriteData(WriteData),
        .MemWrite(MemWrite), .MemRead(MemRead), .ReadData(ReadData), .Hit(Hit),
        .PortIn(PortIn), .PortOut(PortOut), .TxData(TxData), .TxValid(TxValid),
        .TxReady(TxReady)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] st(input int cnt, input bit ovf, input bit full,
                                       input bit empty, input bit chg);
        logic [4:0] c;
        c = 5'(cnt);
        return {21'd0, c, 2'd0, ovf, full, empty, chg};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        Address   = a;
        WriteData = d;
        MemWrite  = 1'b1;
        tick();
        MemWrite  = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        Address = a;
        MemRead = 1'b1;
        #1;
        chk(tag, ReadData, exp);
        MemRead = 1'b0;
    endtask

    initial begin
        reset = 1'b1; Address = 32'd0; WriteData = 32'd0;
        MemWrite = 1'b0; MemRead = 1'b0; PortIn = 8'h00; TxReady = 1'b0;
        tick();
        tick();
        // Decode and load path stay live while reset is held
        rd_chk("reset_status_during", A_ST, 32'h00000002);
        chk("reset_hit", {31'd0, Hit}, 32'd1);
        reset = 1'b0;
        tick();
        chk("reset_txvalid", {31'd0, TxValid}, 32'd0);
        chk("reset_portout", PortOut, 32'd0);
        rd_chk("reset_status", A_ST, 32'h00000002);

        wr(A_OUT, 32'hA5A5_0001);
        chk("portout_store", PortOut, 32'hA5A50001);
        rd_chk("portout_load", A_OUT, 32'hA5A50001);
        rd_chk("portout_lowbits", 32'h10011003, 32'hA5A50001);
        rd_chk("miss_readdata", 32'h10010000, 32'd0);
        chk("miss_hit", {31'd0, Hit}, 32'd0);
        wr(32'h10010000, 32'hDEAD_BEEF);
        chk("miss_no_write", PortOut, 32'hA5A50001);

        // Simultaneous load and store: load sees the old value
        Address = A_OUT; WriteData = 32'h0000_1234; MemWrite = 1'b1; MemRead = 1'b1;
        #1;
        chk("rw_prewrite", ReadData, 32'hA5A50001);
        tick();
        MemWrite = 1'b0; MemRead = 1'b0;
        chk("rw_postwrite", PortOut, 32'h00001234);

        PortIn = 8'h3C;
        tick();
        rd_chk("portin_edge1", A_IN, 32'h00000000);
        tick();
        rd_chk("portin_edge2", A_IN, 32'h0000003C);
        rd_chk("chg_edge2", A_ST, st(0, 0, 0, 1, 0));
        tick();
        rd_chk("chg_edge3", A_ST, st(0, 0, 0, 1, 1));
        wr(A_ST, 32'h1);
        rd_chk("chg_clear", A_ST, st(0, 0, 0, 1, 0));

        // New input change lands on the same edge as a CHG clear
        PortIn = 8'h3D;
        tick();
        tick();
        wr(A_ST, 32'h1);
        rd_chk("chg_set_wins", A_ST, st(0, 0, 0, 1, 1));
        wr(A_ST, 32'h1);
        rd_chk("chg_clear2", A_ST, st(0, 0, 0, 1, 0));

        TxReady = 1'b0;
        wr(A_TX, 32'd1);
        chk("tx_valid_after_push", {31'd0, TxValid}, 32'd1);
        wr(A_TX, 32'd2);
        wr(A_TX, 32'd3);
        chk("tx_head_stable", TxData, 32'd1);
        wr(A_TX, 32'd4);
        rd_chk("fifo_full_status", A_ST, st(4, 0, 1, 0, 0));
        wr(A_TX, 32'd5);
        rd_chk("fifo_ovf_status", A_ST, st(4, 1, 1, 0, 0));
        chk("ovf_head", TxData, 32'd1);
        rd_chk("tx_data_read_zero", A_TX, 32'd0);

        // Full FIFO: push and pop together
        TxReady = 1'b1;
        Address = A_TX; WriteData = 32'd9; MemWrite = 1'b1;
        #1;
        chk("pop_head_1", TxData, 32'd1);
        tick();
        MemWrite = 1'b0;
        rd_chk("full_pushpop_status", A_ST, st(4, 1, 1, 0, 0));
        chk("pop_head_2", TxData, 32'd2);
        tick();
        chk("pop_head_3", TxData, 32'd3);
        tick();
        chk("pop_head_4", TxData, 32'd4);
        tick();
        chk("pop_head_9", TxData, 32'd9);
        tick();
        chk("drained_txvalid", {31'd0, TxValid}, 32'd0);
        rd_chk("drained_status", A_ST, st(0, 1, 0, 1, 0));
        wr(A_ST, 32'h8);
        rd_chk("ovf_clear", A_ST, st(0, 0, 0, 1, 0));

        // Empty FIFO, consumer ready: no bypass, one cycle of valid
        Address = A_TX; WriteData = 32'h77; MemWrite = 1'b1;
        #1;
        chk("nobypass_txvalid", {31'd0, TxValid}, 32'd0);
        tick();
        MemWrite = 1'b0;
        chk("push_empty_txvalid", {31'd0, TxValid}, 32'd1);
        chk("push_empty_txdata", TxData, 32'h77);
        rd_chk("push_empty_status", A_ST, st(1, 0, 0, 0, 0));
        tick();
        chk("popped_txvalid", {31'd0, TxValid}, 32'd0);
        rd_chk("popped_status", A_ST, 32'h00000002);

        TxReady = 1'b0;
        wr(A_TX, 32'h0A);
        wr(A_TX, 32'h0B);
        rd_chk("two_queued_status", A_ST, st(2, 0, 0, 0, 0));
        // Reset competes with a store and a ready handshake
        reset = 1'b1; TxReady = 1'b1;
        Address = A_OUT; WriteData = 32'h55; MemWrite = 1'b1;
        tick();
        MemWrite = 1'b0;
        chk("reset_mid_txvalid", {31'd0, TxValid}, 32'd0);
        chk("reset_mid_portout", PortOut, 32'd0);
        rd_chk("reset_mid_status", A_ST, 32'h00000002);
        rd_chk("reset_mid_portin", A_IN, 32'd0);
        reset = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
